// File: rtl/interface_pkg.sv
// Shared AHB encodings and refill controller types.
package interface_pkg;

   // AHB HTRANS encoding.
   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } trans_types_t;

   // AHB HBURST encoding.
   typedef enum logic [2:0] {
      BURST_SINGLE = 3'd0,
      BURST_INCR   = 3'd1,
      BURST_WRAP4  = 3'd2,
      BURST_INCR4  = 3'd3,
      BURST_WRAP8  = 3'd4,
      BURST_INCR8  = 3'd5,
      BURST_WRAP16 = 3'd6,
      BURST_INCR16 = 3'd7
   } burst_types_t;

   // Refill controller states.
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      BURST,
      FILL,
      ERR
   } refill_states_t;

   // Clears the in-line byte offset of a 16-byte WRAP4 line.
   localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // Next word offset within the line; the 4-bit width makes it wrap mod 16.
   function automatic logic [3:0] wrap4_next(input logic [3:0] off);
      return off + 4'd4;
   endfunction

endpackage

// File: rtl/refill_line_buf.sv
// Four-word line buffer: indexed 32-bit write, whole-line 128-bit read.
module refill_line_buf (
   input  logic         clk,
   input  logic         rstn,
   input  logic         wr_en,
   input  logic [1:0]   wr_idx,
   input  logic [31:0]  wr_data,
   output logic [127:0] rd_data
);

   logic [31:0] words [4];

   // Word storage, cleared by reset, written one word per beat.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < 4; i++) begin
            words[i] <= '0;
         end
      end else if (wr_en) begin
         words[wr_idx] <= wr_data;
      end
   end

   assign rd_data = {words[3], words[2], words[1], words[0]};

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction cache line refill over an AHB WRAP4 burst, critical word first.
module icache_refill_ctrl
   import interface_pkg::*;
(
   input  logic         clk,
   input  logic         rstn,
   input  logic         miss_req,
   input  logic [31:0]  miss_addr,
   output logic         miss_ack,
   output logic [31:0]  m_haddr,
   output logic [1:0]   m_htrans,
   output logic [2:0]   m_hburst,
   output logic         m_hwrite,
   output logic [2:0]   m_hsize,
   input  logic         m_hready,
   input  logic [31:0]  m_hrdata,
   input  logic         m_hresp,
   output logic         crit_valid,
   output logic [31:0]  crit_data,
   output logic         fill_valid,
   output logic [31:0]  fill_addr,
   output logic [127:0] fill_data,
   output logic         fill_err
);

   refill_states_t state, state_next;
   logic [31:0]    base;
   logic [3:0]     offset;
   logic [1:0]     beat;
   logic           capture;
   logic           accept;
   logic [1:0]     slot;
   logic           unused_addr_bits;

   assign unused_addr_bits = ^miss_addr[1:0];

   assign accept = (state == IDLE) && miss_req;
   // offset already points at the next address phase, so the word in the
   // current data phase sits one slot behind it
   assign slot   = offset[3:2] - 2'd1;

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and registered-state-only AHB address phase outputs.
   always_comb begin
      state_next = state;
      m_htrans   = TRANS_IDLE;
      m_haddr    = '0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (miss_req) state_next = ADDR;
         end
         ADDR: begin
            m_htrans = TRANS_NONSEQ;
            m_haddr  = base | {28'd0, offset};
            if (m_hready) state_next = BURST;
         end
         BURST: begin
            m_htrans = (beat == 2'd3) ? TRANS_IDLE : TRANS_SEQ;
            m_haddr  = base | {28'd0, offset};
            if (m_hresp) begin
               state_next = ERR;
            end else if (m_hready) begin
               capture = 1'b1;
               if (beat == 2'd3) state_next = FILL;
            end
         end
         FILL:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request latch, wrap offset/beat tracking and pulse outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         base       <= '0;
         offset     <= '0;
         beat       <= '0;
         miss_ack   <= 1'b0;
         crit_valid <= 1'b0;
         crit_data  <= '0;
      end else begin
         miss_ack   <= accept;
         crit_valid <= capture && (beat == 2'd0);
         if (accept) begin
            base   <= miss_addr & WRAP4_BOUNDARY_MASK;
            offset <= {miss_addr[3:2], 2'b00};
            beat   <= '0;
         end
         if (((state == ADDR) && m_hready) || capture) begin
            offset <= wrap4_next(offset);
         end
         if (capture) begin
            beat <= beat + 2'd1;
            if (beat == 2'd0) crit_data <= m_hrdata;
         end
      end
   end

   refill_line_buf u_line_buf (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (capture),
      .wr_idx  (slot),
      .wr_data (m_hrdata),
      .rd_data (fill_data)
   );

   assign m_hburst   = BURST_WRAP4;
   assign m_hwrite   = 1'b0;
   assign m_hsize    = HSIZE_WORD;
   assign fill_valid = (state == FILL);
   assign fill_err   = (state == ERR);
   assign fill_addr  = base;

endmodule
